// File: rtl/stream_xbar_pkg.sv
// rtl/stream_xbar_pkg.sv - shared defaults, arbiter state type and index helper for the stream crossbar
package stream_xbar_pkg;

   localparam int S_DATA_COUNT_DEF = 2;
   localparam int M_DATA_COUNT_DEF = 3;
   localparam int T_ID___WIDTH_DEF = (S_DATA_COUNT_DEF > 1) ? $clog2(S_DATA_COUNT_DEF) : 1;
   localparam int T_DEST_WIDTH_DEF = (M_DATA_COUNT_DEF > 1) ? $clog2(M_DATA_COUNT_DEF) : 1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Index of the set bit in a one-hot vector; OR-folding keeps it a flat mux tree.
   function automatic int unsigned onehot_to_index(input logic [31:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) begin
            idx = idx | unsigned'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - single-output packet arbiter with round-robin pointer
module stream_rr_arbiter
   import stream_xbar_pkg::*;
#(
   parameter int N_REQ = S_DATA_COUNT_DEF,
   parameter int PTR_W = T_ID___WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_REQ-1:0] cand_i,
   input  logic             last_hs_i,
   output logic [N_REQ-1:0] grant_o,
   output logic             busy_o
);

   arb_state_t       state_q;
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] idx;
   logic [N_REQ-1:0] pick;
   logic             found;

   // first candidate at or above the pointer, wrapping back to source 0
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
         if (!found && cand_i[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   // pointer moves to the source just after the one finishing its packet
   assign ptr_next = PTR_W'((onehot_to_index(32'(grant_o)) + 1) % N_REQ);

   // packet ownership FSM: grant latched at packet head, released on last handshake
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         grant_o <= '0;
         busy_o  <= 1'b0;
         ptr_q   <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (found) begin
                  state_q <= ARB_BUSY;
                  grant_o <= pick;
                  busy_o  <= 1'b1;
               end
            end
            ARB_BUSY: begin
               if (last_hs_i) begin
                  state_q <= ARB_IDLE;
                  grant_o <= '0;
                  busy_o  <= 1'b0;
                  ptr_q   <= ptr_next;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               grant_o <= '0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/stream_xbar_arbiter.sv
// rtl/stream_xbar_arbiter.sv - per-output round-robin packet arbiter for the stream crossbar
module stream_xbar_arbiter
   import stream_xbar_pkg::*;
#(
   parameter  int S_DATA_COUNT = S_DATA_COUNT_DEF,
   parameter  int M_DATA_COUNT = M_DATA_COUNT_DEF,
   localparam int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1,
   localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
   input  logic [S_DATA_COUNT-1:0]                   s_last_i,
   input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
   output logic [S_DATA_COUNT-1:0]                   s_ready_o,
   input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
   output logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant_o,
   output logic [M_DATA_COUNT-1:0]                   busy_o,
   output logic [S_DATA_COUNT-1:0]                   dest_err_o
);

   logic [S_DATA_COUNT-1:0]                   src_granted;
   logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] cand;
   logic [M_DATA_COUNT-1:0]                   last_hs;

   // a source already owning any output cannot start a second packet elsewhere
   always_comb begin
      src_granted = '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         src_granted = src_granted | grant_o[m];
      end
   end

   // candidate sets per output and end-of-packet handshake on the granted path
   always_comb begin
      cand    = '0;
      last_hs = '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         for (int s = 0; s < S_DATA_COUNT; s++) begin
            cand[m][s] = s_valid_i[s] & ~src_granted[s] & (int'(s_dest_i[s]) == m);
         end
         last_hs[m] = m_ready_i[m] & (|(grant_o[m] & s_valid_i & s_last_i));
      end
   end

   // slave ready is returned only to the source holding that output
   always_comb begin
      s_ready_o = '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
         s_ready_o = s_ready_o | (grant_o[m] & {S_DATA_COUNT{m_ready_i[m]}});
      end
   end

   // out-of-range destinations are flagged; they never enter a candidate set
   always_comb begin
      dest_err_o = '0;
      for (int s = 0; s < S_DATA_COUNT; s++) begin
         dest_err_o[s] = s_valid_i[s] & (int'(s_dest_i[s]) >= M_DATA_COUNT);
      end
   end

   for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_out
      stream_rr_arbiter #(
         .N_REQ (S_DATA_COUNT),
         .PTR_W (T_ID___WIDTH)
      ) u_arb (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .cand_i    (cand[m]),
         .last_hs_i (last_hs[m]),
         .grant_o   (grant_o[m]),
         .busy_o    (busy_o[m])
      );
   end

endmodule

// File: tb/tb_stream_xbar_arbiter.sv
// tb/tb_stream_xbar_arbiter.sv - self-checking bench for stream_xbar_arbiter
module tb_stream_xbar_arbiter;

   localparam int S = 2;
   localparam int M = 3;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [S-1:0]     s_valid_i;
   logic [S-1:0]     s_last_i;
   logic [S-1:0][1:0] s_dest_i;
   logic [S-1:0]     s_ready_o;
   logic [M-1:0]     m_ready_i;
   logic [M-1:0][S-1:0] grant_o;
   logic [M-1:0]     busy_o;
   logic [S-1:0]     dest_err_o;

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model: which source owns each output (-1 = free) and its rr pointer
   int owner [M];
   int ptr   [M];
   int nxt_owner [M];
   int nxt_ptr   [M];
   logic [M-1:0][S-1:0] exp_grant;
   logic [M-1:0]        exp_busy;
   logic [S-1:0]        exp_ready;
   logic [S-1:0]        exp_err;

   // well-behaved packet sources used by the directed scenarios
   int pkts_left  [S];
   int beat_len   [S];
   int beats_left [S];
   int dst        [S];

   always #5 clk_i = ~clk_i;

   stream_xbar_arbiter #(
      .S_DATA_COUNT (S),
      .M_DATA_COUNT (M)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .s_valid_i  (s_valid_i),
      .s_last_i   (s_last_i),
      .s_dest_i   (s_dest_i),
      .s_ready_o  (s_ready_o),
      .m_ready_i  (m_ready_i),
      .grant_o    (grant_o),
      .busy_o     (busy_o),
      .dest_err_o (dest_err_o)
   );

   function automatic bit src_owns(input int s);
      for (int m = 0; m < M; m++) begin
         if (owner[m] == s) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_eval();
      int s;
      exp_grant = '0;
      exp_busy  = '0;
      exp_ready = '0;
      exp_err   = '0;
      for (int m = 0; m < M; m++) begin
         nxt_owner[m] = owner[m];
         nxt_ptr[m]   = ptr[m];
         if (owner[m] >= 0) begin
            exp_grant[m][owner[m]] = 1'b1;
            exp_busy[m] = 1'b1;
            if (m_ready_i[m]) exp_ready[owner[m]] = 1'b1;
         end
      end
      for (int k = 0; k < S; k++) begin
         exp_err[k] = s_valid_i[k] && (int'(s_dest_i[k]) >= M);
      end
      for (int m = 0; m < M; m++) begin
         if (owner[m] >= 0) begin
            if (s_valid_i[owner[m]] && m_ready_i[m] && s_last_i[owner[m]]) begin
               nxt_owner[m] = -1;
               nxt_ptr[m]   = (owner[m] + 1) % S;
            end
         end else begin
            for (int k = 0; k < S; k++) begin
               s = (ptr[m] + k) % S;
               if (nxt_owner[m] < 0 && s_valid_i[s] && int'(s_dest_i[s]) == m && !src_owns(s)) begin
                  nxt_owner[m] = s;
               end
            end
         end
      end
      if (rst_i) begin
         for (int m = 0; m < M; m++) begin
            nxt_owner[m] = -1;
            nxt_ptr[m]   = 0;
         end
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk_i);
      for (int m = 0; m < M; m++) begin
         owner[m] = nxt_owner[m];
         ptr[m]   = nxt_ptr[m];
      end
      #1;
   endtask

   task automatic drive_src();
      for (int s = 0; s < S; s++) begin
         s_valid_i[s] = (pkts_left[s] > 0);
         s_last_i[s]  = (beats_left[s] == 1);
         s_dest_i[s]  = 2'(dst[s]);
      end
   endtask

   task automatic advance_src();
      for (int s = 0; s < S; s++) begin
         if (s_valid_i[s] && exp_ready[s]) begin
            beats_left[s]--;
            if (beats_left[s] == 0) begin
               pkts_left[s]--;
               beats_left[s] = beat_len[s];
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_i     = 1'b1;
      s_valid_i = '0;
      s_last_i  = '0;
      s_dest_i  = '0;
      m_ready_i = '1;
      for (int s = 0; s < S; s++) begin
         pkts_left[s] = 0; beat_len[s] = 1; beats_left[s] = 1; dst[s] = 0;
      end
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      s_valid_i = 2'b11;
      s_last_i  = 2'b00;
      s_dest_i[0] = 2'd0;
      s_dest_i[1] = 2'd1;
      m_ready_i = 3'b111;
      for (int m = 0; m < M; m++) begin owner[m] = -1; ptr[m] = 0; end
      tick();
      tick();
      #2;
      tests_run++;
      if (grant_o !== '0) begin tests_failed++; $display("FAIL reset_grant: got %h expected 0", grant_o); end
      tests_run++;
      if (s_ready_o !== '0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 00", s_ready_o); end
      tests_run++;
      if (busy_o !== '0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 000", busy_o); end
      rst_i = 1'b0;
      #2;
      tests_run++;
      if (grant_o !== '0) begin tests_failed++; $display("FAIL reset_release_grant: got %h expected 0", grant_o); end
      tick();
      #2;
      tests_run++;
      if (grant_o[0] !== 2'b01 || grant_o[1] !== 2'b10) begin
         tests_failed++; $display("FAIL reset_first_grant: got %h expected grant0=01 grant1=10", grant_o);
      end
      tests_run++;
      if (busy_o !== 3'b011) begin tests_failed++; $display("FAIL reset_first_busy: got %b expected 011", busy_o); end
   endtask

   task automatic test_contention();
      logic [S-1:0] tbl1 [9];
      logic [S-1:0] tbl2 [5];
      tbl1 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
      tbl2 = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      do_reset();
      for (int s = 0; s < S; s++) begin
         pkts_left[s] = 1; beat_len[s] = 3; beats_left[s] = 3; dst[s] = 1;
      end
      for (int c = 0; c < 9; c++) begin
         drive_src(); #2; model_eval();
         tests_run++;
         if (grant_o[1] !== tbl1[c]) begin tests_failed++; $display("FAIL contention_seq c%0d: got %b expected %b", c, grant_o[1], tbl1[c]); end
         tests_run++;
         if (grant_o !== exp_grant) begin tests_failed++; $display("FAIL contention_model c%0d: got %h expected %h", c, grant_o, exp_grant); end
         tests_run++;
         if (s_ready_o !== exp_ready) begin tests_failed++; $display("FAIL contention_ready c%0d: got %b expected %b", c, s_ready_o, exp_ready); end
         advance_src(); tick();
      end
      // single-beat packets: pointer back at source 0, one-cycle grants
      for (int s = 0; s < S; s++) begin
         pkts_left[s] = 1; beat_len[s] = 1; beats_left[s] = 1; dst[s] = 1;
      end
      for (int c = 0; c < 5; c++) begin
         drive_src(); #2; model_eval();
         tests_run++;
         if (grant_o[1] !== tbl2[c]) begin tests_failed++; $display("FAIL single_beat_seq c%0d: got %b expected %b", c, grant_o[1], tbl2[c]); end
         advance_src(); tick();
      end
   endtask

   task automatic test_fairness();
      int order[$];
      int want [5];
      logic [S-1:0] prev;
      int c;
      want = '{0, 1, 0, 1, 0};
      do_reset();
      for (int s = 0; s < S; s++) begin beat_len[s] = 2; beats_left[s] = 2; dst[s] = 2; end
      pkts_left[0] = 3;
      pkts_left[1] = 2;
      prev = '0;
      c = 0;
      while ((pkts_left[0] > 0 || pkts_left[1] > 0) && c < 40) begin
         drive_src(); #2; model_eval();
         tests_run++;
         if (grant_o !== exp_grant) begin tests_failed++; $display("FAIL fairness_model c%0d: got %h expected %h", c, grant_o, exp_grant); end
         if (grant_o[2] !== '0 && prev === '0) order.push_back(grant_o[2][1] ? 1 : 0);
         prev = grant_o[2];
         advance_src(); tick();
         c++;
      end
      tests_run++;
      if (c >= 40) begin tests_failed++; $display("FAIL fairness_timeout: packets left %0d/%0d expected 0/0", pkts_left[0], pkts_left[1]); end
      tests_run++;
      if (order.size() != 5) begin
         tests_failed++; $display("FAIL fairness_count: got %0d grants expected 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (order[i] != want[i]) begin tests_failed++; $display("FAIL fairness_order[%0d]: got %0d expected %0d", i, order[i], want[i]); end
         end
      end
   endtask

   task automatic test_parallel();
      do_reset();
      pkts_left[0] = 1; beat_len[0] = 4; beats_left[0] = 4; dst[0] = 0;
      pkts_left[1] = 1; beat_len[1] = 4; beats_left[1] = 4; dst[1] = 2;
      for (int c = 0; c < 12; c++) begin
         m_ready_i = 3'($urandom);
         drive_src(); #2; model_eval();
         if (c == 1) begin
            tests_run++;
            if (grant_o[0] !== 2'b01 || grant_o[2] !== 2'b10) begin
               tests_failed++; $display("FAIL parallel_same_edge: got %h expected grant0=01 grant2=10", grant_o);
            end
            tests_run++;
            if (s_ready_o !== {m_ready_i[2], m_ready_i[0]}) begin
               tests_failed++; $display("FAIL parallel_ready_route: got %b expected %b", s_ready_o, {m_ready_i[2], m_ready_i[0]});
            end
         end
         tests_run++;
         if (grant_o !== exp_grant) begin tests_failed++; $display("FAIL parallel_model c%0d: got %h expected %h", c, grant_o, exp_grant); end
         tests_run++;
         if (s_ready_o !== exp_ready) begin tests_failed++; $display("FAIL parallel_ready c%0d: got %b expected %b", c, s_ready_o, exp_ready); end
         advance_src(); tick();
      end
   endtask

   task automatic test_hold();
      do_reset();
      pkts_left[0] = 1; beat_len[0] = 8; beats_left[0] = 8; dst[0] = 1;
      for (int c = 0; c < 12; c++) begin
         if (c >= 2) dst[0] = 0;
         m_ready_i = {1'b1, !(c >= 2 && c <= 5), 1'b1};
         drive_src(); #2; model_eval();
         if (c >= 2 && c <= 5) begin
            tests_run++;
            if (grant_o[1] !== 2'b01 || grant_o[0] !== 2'b00) begin
               tests_failed++; $display("FAIL hold_grant c%0d: got %h expected grant1=01 grant0=00", c, grant_o);
            end
            tests_run++;
            if (s_ready_o[0] !== 1'b0) begin tests_failed++; $display("FAIL hold_stall_ready c%0d: got %b expected 0", c, s_ready_o[0]); end
         end
         tests_run++;
         if (grant_o !== exp_grant) begin tests_failed++; $display("FAIL hold_model c%0d: got %h expected %h", c, grant_o, exp_grant); end
         tests_run++;
         if (busy_o !== exp_busy) begin tests_failed++; $display("FAIL hold_busy c%0d: got %b expected %b", c, busy_o, exp_busy); end
         advance_src(); tick();
      end
   endtask

   task automatic test_illegal_and_reset();
      do_reset();
      pkts_left[0] = 100; beat_len[0] = 1; beats_left[0] = 1; dst[0] = 3;
      for (int c = 0; c < 4; c++) begin
         drive_src(); #2; model_eval();
         tests_run++;
         if (dest_err_o !== 2'b01) begin tests_failed++; $display("FAIL illegal_err c%0d: got %b expected 01", c, dest_err_o); end
         tests_run++;
         if (grant_o !== '0 || s_ready_o !== '0) begin
            tests_failed++; $display("FAIL illegal_grant c%0d: got grant %h ready %b expected 0/00", c, grant_o, s_ready_o);
         end
         advance_src(); tick();
      end
      pkts_left[1] = 1; beat_len[1] = 10; beats_left[1] = 10; dst[1] = 1;
      for (int c = 0; c < 3; c++) begin
         drive_src(); #2; model_eval();
         tests_run++;
         if (grant_o !== exp_grant) begin tests_failed++; $display("FAIL midreset_model c%0d: got %h expected %h", c, grant_o, exp_grant); end
         if (c == 2) begin
            tests_run++;
            if (busy_o !== 3'b010 || grant_o[1] !== 2'b10) begin
               tests_failed++; $display("FAIL midreset_busy_before: got busy %b grant %h expected 010 / grant1=10", busy_o, grant_o);
            end
         end
         advance_src(); tick();
      end
      rst_i = 1'b1;
      drive_src(); #2;
      tests_run++;
      if (grant_o[1] !== 2'b10) begin tests_failed++; $display("FAIL midreset_sync: got %b expected 10", grant_o[1]); end
      tick(); #2;
      tests_run++;
      if (grant_o !== '0 || busy_o !== '0) begin
         tests_failed++; $display("FAIL midreset_clear: got grant %h busy %b expected 0/000", grant_o, busy_o);
      end
      tests_run++;
      if (s_ready_o !== '0) begin tests_failed++; $display("FAIL midreset_ready: got %b expected 00", s_ready_o); end
      rst_i = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst_i     = ($urandom_range(0, 49) == 0);
         s_valid_i = 2'($urandom);
         s_last_i  = 2'($urandom);
         for (int s = 0; s < S; s++) s_dest_i[s] = 2'($urandom_range(0, 3));
         m_ready_i = 3'($urandom);
         #2; model_eval();
         tests_run++;
         if (grant_o !== exp_grant) begin tests_failed++; $display("FAIL random_grant c%0d: got %h expected %h", c, grant_o, exp_grant); end
         tests_run++;
         if (busy_o !== exp_busy) begin tests_failed++; $display("FAIL random_busy c%0d: got %b expected %b", c, busy_o, exp_busy); end
         tests_run++;
         if (s_ready_o !== exp_ready) begin tests_failed++; $display("FAIL random_ready c%0d: got %b expected %b", c, s_ready_o, exp_ready); end
         tests_run++;
         if (dest_err_o !== exp_err) begin tests_failed++; $display("FAIL random_dest_err c%0d: got %b expected %b", c, dest_err_o, exp_err); end
         tick();
      end
      rst_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_contention();
      test_fairness();
      test_parallel();
      test_hold();
      test_illegal_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
